cam_pixel_capture: RTL and testbench

- Front-end stage of the wb_cam path. Samples the raw camera byte bus (vsync, href, 8-bit data) on the pixel clock.
- Assembles each RGB565 byte pair into one RGB332 pixel and tags it with start-of-frame and start-of-line flags.
- Writes 10-bit words into the downstream camera FIFO with a single-cycle write strobe, honouring the FIFO full flag.
- One frame is captured per arm request from the Wishbone side.

---
 rtl/cam_pixel_capture_if.sv | 19 +
 rtl/cam_pixel_capture.sv | 190 +++++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pixel_capture_if.sv
// Write-side bus between the pixel capture stage and the downstream camera FIFO.
// The capture stage is the master; the FIFO is the slave and returns its full flag.
interface cam_pixel_capture_if;
    logic       fifo_wr;
    logic [9:0] fifo_data;
    logic       fifo_full;

    modport master (
        output fifo_wr,
        output fifo_data,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr,
        input  fifo_data,
        output fifo_full
    );
endinterface

// File: rtl/cam_pixel_capture.sv
// Camera front end: packs RGB565 byte pairs into RGB332 words tagged {sof, sol} and writes them
// to the camera FIFO, one frame per arm. Define CAM_TEST_PATTERN_EN to add the test_mode input.
module cam_pixel_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int CNT_W    = 10
) (
    input  logic                 Pclk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 vsync,
    input  logic                 href,
    input  logic [7:0]           cam_data,
`ifdef CAM_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    cam_pixel_capture_if.master  fifo,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     pix_cnt,
    output logic [CNT_W-1:0]     line_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic       vsync_r;
    logic       vsync_q;
    logic       href_r;
    logic       href_q;
    logic [7:0] data_r;

    logic       vs_fall;
    logic       vs_rise;
    logic       hr_rise;
    logic       hr_fall;

    logic [5:0] hi_rg;
    logic       phase;
    logic       sof_pend;
    logic       sol_pend;
    logic [7:0] pix_field;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Camera inputs are registered once; data rides along so it stays aligned with href_r.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            vsync_q <= 1'b0;
            href_r  <= 1'b0;
            href_q  <= 1'b0;
            data_r  <= '0;
        end else begin
            vsync_r <= vsync;
            vsync_q <= vsync_r;
            href_r  <= href;
            href_q  <= href_r;
            data_r  <= cam_data;
        end
    end

    assign vs_fall = vsync_q & ~vsync_r;
    assign vs_rise = ~vsync_q & vsync_r;
    assign hr_rise = href_r & ~href_q;
    assign hr_fall = ~href_r & href_q;

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm)     state_nxt = WAIT_VS;
            WAIT_VS: if (vs_fall) state_nxt = CAPTURE;
            CAPTURE: if (vs_rise) state_nxt = DONE;
            DONE:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == WAIT_VS) || (state == CAPTURE);
        frame_done = (state == DONE);
    end

    // hi_rg keeps only the R and G bits of the high byte; the low byte is used straight from data_r.
    always_comb begin
        pix_field = {hi_rg, data_r[4:3]};
`ifdef CAM_TEST_PATTERN_EN
        if (test_mode) begin
            pix_field = pix_cnt[7:0] ^ line_cnt[7:0];
        end
`endif
    end

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            fifo.fifo_wr   <= 1'b0;
            fifo.fifo_data <= '0;
            overflow       <= 1'b0;
            frame_err      <= 1'b0;
            pix_cnt        <= '0;
            line_cnt       <= '0;
            hi_rg          <= '0;
            phase          <= 1'b0;
            sof_pend       <= 1'b0;
            sol_pend       <= 1'b0;
        end else begin
            fifo.fifo_wr <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= 1'b0;
                    if (arm) begin
                        overflow  <= 1'b0;
                        frame_err <= 1'b0;
                        pix_cnt   <= '0;
                        line_cnt  <= '0;
                    end
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        sof_pend <= 1'b1;
                        sol_pend <= 1'b0;
                        phase    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // A vsync rise wins over a simultaneous line end: the dangling line is not counted.
                    if (vs_rise) begin
                        if (line_cnt != CNT_W'(V_LINES)) begin
                            frame_err <= 1'b1;
                        end
                    end else if (hr_fall) begin
                        line_cnt <= sat_inc(line_cnt);
                        if ((pix_cnt != CNT_W'(H_PIXELS)) || phase) begin
                            frame_err <= 1'b1;
                        end
                        phase <= 1'b0;
                    end else if (href_r) begin
                        if (hr_rise) begin
                            hi_rg    <= {data_r[7:5], data_r[2:0]};
                            phase    <= 1'b1;
                            sol_pend <= 1'b1;
                            pix_cnt  <= '0;
                        end else if (!phase) begin
                            hi_rg <= {data_r[7:5], data_r[2:0]};
                            phase <= 1'b1;
                        end else begin
                            // A dropped pixel keeps sof/sol pending so they land on the next written word.
                            phase   <= 1'b0;
                            pix_cnt <= sat_inc(pix_cnt);
                            if (fifo.fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                fifo.fifo_wr   <= 1'b1;
                                fifo.fifo_data <= {sof_pend, sol_pend, pix_field};
                                sof_pend       <= 1'b0;
                                sol_pend       <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    phase <= 1'b0;
                end
                default: begin
                    phase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Randomized bench for cam_pixel_capture: frames are generated as byte/full-flag lists and the
// expected FIFO words and frame status are derived from them by a frame-level model.
`timescale 1ns/1ps
module tb_cam_pixel_capture;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CW = 10;

    logic          Pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic          vsync = 1'b1;
    logic          href = 1'b0;
    logic [7:0]    cam_data = '0;
    logic          busy;
    logic          frame_done;
    logic          overflow;
    logic          frame_err;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] line_cnt;
`ifdef CAM_TEST_PATTERN_EN
    logic          test_mode_tb = 1'b0;
`endif

    cam_pixel_capture_if fifo_bus();

    cam_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .CNT_W(CW)) dut (
        .Pclk       (Pclk),
        .rst_n      (rst_n),
        .arm        (arm),
        .vsync      (vsync),
        .href       (href),
        .cam_data   (cam_data),
`ifdef CAM_TEST_PATTERN_EN
        .test_mode  (test_mode_tb),
`endif
        .fifo       (fifo_bus),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .pix_cnt    (pix_cnt),
        .line_cnt   (line_cnt)
    );

    initial forever #5 Pclk = ~Pclk;

    int checks = 0;
    int failures = 0;

    logic [7:0] fbytes[$];
    int         line_len[$];
    bit         pfull[$];

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    bit         exp_done = 1'b0;
    bit         ignore_wr = 1'b0;
    int         done_seen = 0;
    bit         exp_err;
    bit         exp_ovf;
    int         exp_lines;
    int         exp_pix;
    int         exp_nwr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_field(input logic [7:0] hi, input logic [7:0] lo,
                                             input int p, input int l);
`ifdef CAM_TEST_PATTERN_EN
        if (test_mode_tb) return 8'(p) ^ 8'(l);
`endif
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    // Builds one frame's stimulus; force_ord marks one pixel (frame-wide ordinal) as hitting fifo_full.
    task automatic gen_frame(input int nl, input int len0, input int len_n, input int full_pct,
                             input int force_ord, input bit nominal);
        int ord = 0;
        fbytes.delete();
        line_len.delete();
        pfull.delete();
        for (int l = 0; l < nl; l++) begin
            int len = (l == 0) ? len0 : len_n;
            line_len.push_back(len);
            for (int b = 0; b < len; b++) begin
                if (nominal) fbytes.push_back((b % 2 == 1) ? 8'h1F : ((l == 0 && b == 0) ? 8'hE0 : 8'hA0));
                else         fbytes.push_back(8'($urandom));
            end
            for (int p = 0; p < len / 2; p++) begin
                pfull.push_back((ord == force_ord) || ($urandom_range(0, 99) < full_pct));
                ord++;
            end
        end
    endtask

    task automatic build_model();
        int idx = 0;
        int ord = 0;
        bit sof = 1'b1;
        bit sol;
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        exp_nwr = 0;
        exp_q.delete();
        for (int l = 0; l < line_len.size(); l++) begin
            sol = 1'b1;
            for (int p = 0; p < line_len[l] / 2; p++) begin
                if (pfull[ord]) begin
                    exp_ovf = 1'b1;
                end else begin
                    exp_q.push_back({sof, sol, pix_field(fbytes[idx + 2*p], fbytes[idx + 2*p + 1],
                                                         (p > 1023) ? 1023 : p, l)});
                    sof = 1'b0;
                    sol = 1'b0;
                    exp_nwr++;
                end
                ord++;
            end
            if (line_len[l] != 2 * H) exp_err = 1'b1;
            idx += line_len[l];
        end
        if (line_len.size() != V) exp_err = 1'b1;
        exp_lines = (line_len.size() > 1023) ? 1023 : line_len.size();
        exp_pix   = line_len[line_len.size() - 1] / 2;
        if (exp_pix > 1023) exp_pix = 1023;
    endtask

    // Drives one frame; fifo_full is presented one cycle behind its byte to line up with the DUT's input register.
    task automatic applyStimulus(input bit captured, input bit arm_mid);
        int idx = 0;
        int base = 0;
        int start;
        bit prevf = 1'b0;
        vsync = 1'b1;
        href = 1'b0;
        fifo_bus.fifo_full = 1'b0;
        repeat (3) @(negedge Pclk);
        got_q.delete();
        if (captured) begin
            build_model();
            exp_done = 1'b1;
        end
        vsync = 1'b0;
        repeat (3) @(negedge Pclk);
        if (captured) checkOutput("busy_in_frame", busy, 1);
        start = done_seen;
        for (int l = 0; l < line_len.size(); l++) begin
            href = 1'b1;
            for (int b = 0; b < line_len[l]; b++) begin
                cam_data = fbytes[idx];
                fifo_bus.fifo_full = prevf;
                prevf = (b / 2 < line_len[l] / 2) ? pfull[base + b / 2] : 1'b0;
                idx++;
                if (arm_mid && l == 0 && b == 2) arm = 1'b1;
                @(negedge Pclk);
                arm = 1'b0;
            end
            href = 1'b0;
            fifo_bus.fifo_full = prevf;
            prevf = 1'b0;
            @(negedge Pclk);
            fifo_bus.fifo_full = 1'b0;
            repeat (2) @(negedge Pclk);
            base += line_len[l] / 2;
        end
        vsync = 1'b1;
        if (captured) begin
            for (int i = 0; i < 20 && done_seen == start; i++) @(negedge Pclk);
            checkOutput("frame_done_seen", done_seen - start, 1);
            exp_done = 1'b0;
            repeat (3) @(negedge Pclk);
            checkOutput("frame_done_single", done_seen - start, 1);
            checkOutput("write_count", got_q.size(), exp_nwr);
        end else begin
            repeat (6) @(negedge Pclk);
            checkOutput("write_count_idle", got_q.size(), 0);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge Pclk);
        arm = 1'b0;
        @(negedge Pclk);
    endtask

    // Compare process: every FIFO write against the model queue, every frame_done against frame status.
    always @(posedge Pclk) begin
        #1;
        if (rst_n && fifo_bus.fifo_wr && !ignore_wr) begin
            got_q.push_back(fifo_bus.fifo_data);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got word 0x%0h, expected no write", fifo_bus.fifo_data);
            end else begin
                checkOutput("fifo_word", fifo_bus.fifo_data, exp_q.pop_front());
            end
        end
        if (rst_n && frame_done) begin
            if (!exp_done) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_frame_done: got pulse, expected none");
            end else begin
                checkOutput("frame_err", frame_err, exp_err);
                checkOutput("overflow", overflow, exp_ovf);
                checkOutput("line_cnt", line_cnt, exp_lines);
                checkOutput("pix_cnt", pix_cnt, exp_pix);
                checkOutput("words_left", exp_q.size(), 0);
                checkOutput("busy_at_done", busy, 0);
                done_seen++;
            end
        end
    end

    initial begin
        #900us;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fifo_bus.fifo_full = 1'b0;
        repeat (3) @(negedge Pclk);
        checkOutput("rst_fifo_wr", fifo_bus.fifo_wr, 0);
        checkOutput("rst_fifo_data", fifo_bus.fifo_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        checkOutput("rst_pix_cnt", pix_cnt, 0);
        checkOutput("rst_line_cnt", line_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge Pclk);

        $display("[TB] nominal frame");
        gen_frame(2, 8, 8, 0, -1, 1'b1);
        pulse_arm();
        applyStimulus(1'b1, 1'b0);
        checkOutput("nominal_writes", got_q.size(), 8);
        checkOutput("nominal_word0", got_q[0], 10'h3E3);
        checkOutput("nominal_word1", got_q[1], 10'h0A3);
        checkOutput("nominal_word4_flags", got_q[4][9:8], 2'b01);
        checkOutput("nominal_frame_err", frame_err, 0);

        $display("[TB] fifo full on pixel 2 of line 1");
        gen_frame(2, 8, 8, 0, 1, 1'b0);
        pulse_arm();
        applyStimulus(1'b1, 1'b0);
        checkOutput("drop_writes", got_q.size(), 7);
        checkOutput("overflow_sticky", overflow, 1);

        $display("[TB] fifo full on first pixel");
        gen_frame(2, 8, 8, 0, 0, 1'b0);
        pulse_arm();
        applyStimulus(1'b1, 1'b0);
        checkOutput("sof_carried", got_q[0][9:8], 2'b11);

        $display("[TB] short line with odd byte");
        gen_frame(2, 7, 8, 0, -1, 1'b0);
        pulse_arm();
        applyStimulus(1'b1, 1'b0);
        checkOutput("short_writes", got_q.size(), 7);
        checkOutput("short_frame_err", frame_err, 1);

        $display("[TB] arm in the middle of a frame");
        gen_frame(2, 8, 8, 0, -1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("busy_after_mid_arm", busy, 1);
        gen_frame(2, 8, 8, 0, -1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("mid_arm_sof", got_q[0][9], 1);

        $display("[TB] reset during capture");
        pulse_arm();
        vsync = 1'b1;
        repeat (3) @(negedge Pclk);
        vsync = 1'b0;
        repeat (3) @(negedge Pclk);
        ignore_wr = 1'b1;
        href = 1'b1;
        for (int b = 0; b < 5; b++) begin
            cam_data = 8'($urandom);
            @(negedge Pclk);
        end
        @(posedge Pclk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_fifo_wr", fifo_bus.fifo_wr, 0);
        checkOutput("midrst_fifo_data", fifo_bus.fifo_data, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pix_cnt", pix_cnt, 0);
        checkOutput("midrst_line_cnt", line_cnt, 0);
        checkOutput("midrst_overflow", overflow, 0);
        checkOutput("midrst_frame_err", frame_err, 0);
        @(negedge Pclk);
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        ignore_wr = 1'b0;
        for (int b = 0; b < 3; b++) begin
            cam_data = 8'($urandom);
            @(negedge Pclk);
        end
        href = 1'b0;
        repeat (3) @(negedge Pclk);
        href = 1'b1;
        for (int b = 0; b < 8; b++) begin
            cam_data = 8'($urandom);
            @(negedge Pclk);
        end
        href = 1'b0;
        repeat (3) @(negedge Pclk);
        vsync = 1'b1;
        repeat (6) @(negedge Pclk);
        checkOutput("writes_after_reset", got_q.size(), 0);
        checkOutput("busy_after_reset", busy, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            int nl   = $urandom_range(1, 3);
            int len0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 9)) : 8;
            int lenn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 9)) : 8;
            gen_frame(nl, len0, lenn, 25, -1, 1'b0);
            pulse_arm();
            applyStimulus(1'b1, 1'b0);
        end

        $display("[TB] pixel counter saturation");
        gen_frame(1, 2060, 0, 0, -1, 1'b0);
        pulse_arm();
        applyStimulus(1'b1, 1'b0);
        checkOutput("sat_pix_cnt", pix_cnt, 10'h3FF);

`ifdef CAM_TEST_PATTERN_EN
        $display("[TB] test pattern");
        test_mode_tb = 1'b1;
        gen_frame(2, 8, 8, 0, -1, 1'b0);
        pulse_arm();
        applyStimulus(1'b1, 1'b0);
        checkOutput("pattern_l1_p3", got_q[7][7:0], 8'h02);
        test_mode_tb = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
